// File: rtl/ctrl_decode_stage_if.sv
// ctrl_decode_stage_if
//   Bus bundle for the RV32I decode/control stage.
//   slave  : the decode stage's view (fetch/flush/writeback/out_ready in, bundle out)
//   master : the surrounding pipeline's view (the reverse)
//   Groups the fetch handshake (in_*), flush, writeback retire (wb_*),
//   the registered control bundle (out_*) and the perf counters.
interface ctrl_decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              flush;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [REG_AW-1:0] out_rd;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic              out_rs1_en;
  logic              out_rs2_en;
  logic              out_br_or_jmp;
  logic              out_br_used;
  logic              out_use_jalr;
  logic [2:0]        out_func3;
  logic              out_func1;
  logic              out_reg_write;
  logic [2:0]        out_func_mem;
  logic              out_illegal;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, wb_valid, wb_rd, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_rs1_en, out_rs2_en, out_br_or_jmp, out_br_used, out_use_jalr,
           out_func3, out_func1, out_reg_write, out_func_mem, out_illegal,
           stall_cnt, flush_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, wb_valid, wb_rd, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_rs1_en, out_rs2_en, out_br_or_jmp, out_br_used, out_use_jalr,
           out_func3, out_func1, out_reg_write, out_func_mem, out_illegal,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage
//   Registered RV32I decode/control stage. Decodes the fetched instruction into
//   the ALU/branch/mem/writeback control bundle, holds it in a valid/ready
//   output register, stalls RAW/WAW hazards through a pending-write scoreboard
//   and squashes the held bundle on flush.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ctrl_decode_stage_if.slave: in_* fetch handshake, flush, wb_* retire,
//          out_* control bundle, stall_cnt/flush_cnt
// Optional: define CTRL_PERF_CNT_EN for saturating stall/flush counters;
//   otherwise stall_cnt/flush_cnt are tied to 0.
module ctrl_decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  ctrl_decode_stage_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_en;
    logic              rs2_en;
    logic              br_or_jmp;
    logic              br_used;
    logic              use_jalr;
    logic [2:0]        func3;
    logic              func1;
    logic              reg_write;
    logic [2:0]        func_mem;
    logic              illegal;
  } ctrl_t;

  ctrl_t               dec, q;
  logic                vld_q;
  logic [NUM_REGS-1:0] sb, sb_nxt;
  logic                hazard, accept;
  logic [6:0]          opc;
  logic [2:0]          f3;

  assign opc = bus.in_instr[6:0];
  assign f3  = bus.in_instr[14:12];

  // Bits carried by immediates only; decode never looks at them.
  logic unused_instr;
  assign unused_instr = ^{bus.in_instr[31], bus.in_instr[29:25]};

  always_comb begin
    dec           = '0;
    dec.pc        = bus.in_pc;
    dec.rd        = bus.in_instr[11:7];
    dec.rs1       = bus.in_instr[19:15];
    dec.rs2       = bus.in_instr[24:20];
    unique case (opc)
      OP_LUI, OP_AUIPC: dec.reg_write = 1'b1;
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.br_or_jmp = 1'b1;
        dec.br_used   = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.rs1_en    = 1'b1;
        dec.br_used   = 1'b1;
        dec.use_jalr  = 1'b1;
      end
      OP_BRANCH: begin
        dec.rs1_en  = 1'b1;
        dec.rs2_en  = 1'b1;
        dec.br_used = 1'b1;
        dec.func3   = f3;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.rs1_en    = 1'b1;
        dec.func_mem  = f3;
      end
      OP_STORE: begin
        dec.rs1_en   = 1'b1;
        dec.rs2_en   = 1'b1;
        dec.func_mem = f3;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.rs1_en    = 1'b1;
        dec.func3     = f3;
        // instr[30] only distinguishes SRAI from SRLI; elsewhere it is immediate.
        dec.func1     = (f3 == 3'b101) & bus.in_instr[30];
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        dec.rs1_en    = 1'b1;
        dec.rs2_en    = 1'b1;
        dec.func3     = f3;
        dec.func1     = bus.in_instr[30];
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // sb[0] is held at 0, so x0 never contributes to any hazard term.
  assign hazard = bus.in_valid & ((dec.rs1_en    & sb[dec.rs1]) |
                                  (dec.rs2_en    & sb[dec.rs2]) |
                                  (dec.reg_write & sb[dec.rd]));

  assign bus.in_ready = (!vld_q | bus.out_ready) & !hazard & !bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      q     <= '0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      q     <= dec;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Clears first, then the accept's set, so a same-cycle set of one index wins.
  // A squashed writer is the only pending writer of its rd (WAW stall), so
  // dropping its bit on flush is exact.
  always_comb begin
    sb_nxt = sb;
    if (bus.wb_valid) sb_nxt[bus.wb_rd] = 1'b0;
    if (bus.flush & vld_q & q.reg_write) sb_nxt[q.rd] = 1'b0;
    if (accept & dec.reg_write) sb_nxt[dec.rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_nxt;
  end

  assign bus.out_valid     = vld_q;
  assign bus.out_pc        = q.pc;
  assign bus.out_rd        = q.rd;
  assign bus.out_rs1       = q.rs1;
  assign bus.out_rs2       = q.rs2;
  assign bus.out_rs1_en    = q.rs1_en;
  assign bus.out_rs2_en    = q.rs2_en;
  assign bus.out_br_or_jmp = q.br_or_jmp;
  assign bus.out_br_used   = q.br_used;
  assign bus.out_use_jalr  = q.use_jalr;
  assign bus.out_func3     = q.func3;
  assign bus.out_func1     = q.func1;
  assign bus.out_reg_write = q.reg_write;
  assign bus.out_func_mem  = q.func_mem;
  assign bus.out_illegal   = q.illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard & !bus.flush & ~&stall_q) stall_q <= stall_q + 1'b1;
      if (bus.flush & vld_q & ~&flush_q)   flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage
//   Directed bench for ctrl_decode_stage. Inputs are driven and outputs are
//   sampled at the falling clock edge; every expected value is hand-computed.
module tb_ctrl_decode_stage;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  ctrl_decode_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(16)) bus ();

  ctrl_decode_stage #(.XLEN(32), .NUM_REGS(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [31:0] I_ADDI_X5  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] I_ADD_X6   = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] I_LW_X7    = 32'h0001_2383; // lw   x7,0(x2)
  localparam logic [31:0] I_JAL_X1   = 32'h0000_00EF; // jal  x1,0
  localparam logic [31:0] I_ADDI_X10 = 32'h0000_8513; // addi x10,x1,0
  localparam logic [31:0] I_SRAI     = 32'h4022_5193; // srai x3,x4,2
  localparam logic [31:0] I_SLLI     = 32'h0022_1193; // slli x3,x4,2
  localparam logic [31:0] I_ILL_X8   = 32'h0000_047F; // opcode 7'h7f, rd=8
  localparam logic [31:0] I_ADDI_X8  = 32'h0010_0413; // addi x8,x0,1

`ifdef CTRL_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
  endtask

  task automatic retire(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_reg_write", bus.out_reg_write, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);

    // 1: reset mid-stream with a held bundle and sb[5] pending
    @(negedge clk);
    bus.out_ready = 1'b0;
    present(I_ADDI_X5, 32'h100);
    tick();
    idle();
    chk("mid_out_valid_before", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_out_valid", bus.out_valid, 0);
    chk("mid_async_in_ready", bus.in_ready, 1);
    chk("mid_async_out_rd", bus.out_rd, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    present(I_ADD_X6, 32'h104);
    #1;
    chk("mid_sb5_cleared", bus.in_ready, 1);
    tick();
    idle();
    chk("mid_add_rd", bus.out_rd, 6);
    retire(5'd6);
    tick();
    bus.wb_valid = 1'b0;
    chk("mid_consumed", bus.out_valid, 0);

    // 2: RAW stall, released the cycle after writeback
    present(I_ADDI_X5, 32'h200);
    #1;
    chk("raw_addi_ready", bus.in_ready, 1);
    tick();
    chk("raw_addi_valid", bus.out_valid, 1);
    chk("raw_addi_rd", bus.out_rd, 5);
    chk("raw_addi_rs1_en", bus.out_rs1_en, 1);
    chk("raw_addi_rs2_en", bus.out_rs2_en, 0);
    chk("raw_addi_reg_write", bus.out_reg_write, 1);
    present(I_ADD_X6, 32'h204);
    #1;
    chk("raw_add_stall", bus.in_ready, 0);
    tick();
    chk("raw_drained", bus.out_valid, 0);
    retire(5'd5);
    #1;
    chk("raw_no_bypass", bus.in_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("raw_release", bus.in_ready, 1);
    tick();
    idle();
    chk("raw_add_valid", bus.out_valid, 1);
    chk("raw_add_pc", bus.out_pc, 32'h204);
    chk("raw_add_rs2_en", bus.out_rs2_en, 1);
    chk("raw_add_func3", bus.out_func3, 0);
    chk("raw_add_func1", bus.out_func1, 0);
    chk("raw_stall_cnt", bus.stall_cnt, 2 * PERF);
    retire(5'd6);
    tick();
    bus.wb_valid = 1'b0;

    // 3: WAW stall on two loads to x7
    present(I_LW_X7, 32'h300);
    tick();
    chk("waw_lw1_func_mem", bus.out_func_mem, 3'b010);
    chk("waw_lw1_rs2_en", bus.out_rs2_en, 0);
    chk("waw_lw1_func3", bus.out_func3, 0);
    present(I_LW_X7, 32'h304);
    #1;
    chk("waw_stall", bus.in_ready, 0);
    tick();
    retire(5'd7);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("waw_release", bus.in_ready, 1);
    tick();
    idle();
    chk("waw_lw2_pc", bus.out_pc, 32'h304);
    chk("waw_lw2_func_mem", bus.out_func_mem, 3'b010);
    chk("waw_lw2_reg_write", bus.out_reg_write, 1);
    chk("waw_stall_cnt", bus.stall_cnt, 4 * PERF);
    retire(5'd7);
    tick();
    bus.wb_valid = 1'b0;

    // 4: held JAL squashed by flush
    bus.out_ready = 1'b0;
    present(I_JAL_X1, 32'h400);
    tick();
    chk("jal_br_or_jmp", bus.out_br_or_jmp, 1);
    chk("jal_br_used", bus.out_br_used, 1);
    chk("jal_use_jalr", bus.out_use_jalr, 0);
    chk("jal_rs1_en", bus.out_rs1_en, 0);
    present(I_ADDI_X5, 32'h404);
    #1;
    chk("hold_in_ready", bus.in_ready, 0);
    tick();
    chk("hold_pc_stable", bus.out_pc, 32'h400);
    chk("hold_valid", bus.out_valid, 1);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_cnt", bus.flush_cnt, 1 * PERF);
    present(I_ADDI_X10, 32'h500);
    #1;
    chk("flush_sb1_cleared", bus.in_ready, 1);
    tick();
    idle();
    chk("post_flush_rs1", bus.out_rs1, 1);
    chk("post_flush_rd", bus.out_rd, 10);
    retire(5'd10);
    tick();
    bus.wb_valid = 1'b0;

    // 5: shift-immediate func1
    present(I_SRAI, 32'h600);
    tick();
    idle();
    chk("srai_func1", bus.out_func1, 1);
    chk("srai_func3", bus.out_func3, 3'b101);
    retire(5'd3);
    tick();
    bus.wb_valid = 1'b0;
    present(I_SLLI, 32'h604);
    tick();
    idle();
    chk("slli_func1", bus.out_func1, 0);
    chk("slli_func3", bus.out_func3, 3'b001);
    retire(5'd3);
    tick();
    bus.wb_valid = 1'b0;

    // 6: illegal opcode leaves no pending write behind
    present(I_ILL_X8, 32'h700);
    tick();
    chk("ill_flag", bus.out_illegal, 1);
    chk("ill_reg_write", bus.out_reg_write, 0);
    chk("ill_rs1_en", bus.out_rs1_en, 0);
    chk("ill_br_used", bus.out_br_used, 0);
    present(I_ADDI_X8, 32'h704);
    #1;
    chk("ill_no_stall", bus.in_ready, 1);
    tick();
    idle();
    chk("ill_follow_flag", bus.out_illegal, 0);
    chk("ill_follow_rd", bus.out_rd, 8);
    chk("final_stall_cnt", bus.stall_cnt, 4 * PERF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
